// File: rtl/irq_sequencer_if.sv
// ---------------------------------------------------------------------------
// irq_sequencer_if
// Bus between the interrupt sequencer and its environment (interrupt sources,
// mask CSR, pipeline/branch unit).
//   master : drives IrqLines, MaskWe, MaskIn, GlobalEn, IrqAck, PcIn, RetiDone
//            and observes IRQ, VectorAddr, ReturnAddr, ActiveId, InService,
//            Pending.
//   slave  : the sequencer side, with the opposite directions.
// ---------------------------------------------------------------------------
interface irq_sequencer_if #(
  parameter int NUM_SRC = 8,
  parameter int ADDR_W  = 32
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] IrqLines;
  logic               MaskWe;
  logic [NUM_SRC-1:0] MaskIn;
  logic               GlobalEn;
  logic               IrqAck;
  logic [ADDR_W-1:0]  PcIn;
  logic               RetiDone;

  logic               IRQ;
  logic [ADDR_W-1:0]  VectorAddr;
  logic [ADDR_W-1:0]  ReturnAddr;
  logic [ID_W-1:0]    ActiveId;
  logic               InService;
  logic [NUM_SRC-1:0] Pending;

  modport master (
    output IrqLines, MaskWe, MaskIn, GlobalEn, IrqAck, PcIn, RetiDone,
    input  IRQ, VectorAddr, ReturnAddr, ActiveId, InService, Pending
  );

  modport slave (
    input  IrqLines, MaskWe, MaskIn, GlobalEn, IrqAck, PcIn, RetiDone,
    output IRQ, VectorAddr, ReturnAddr, ActiveId, InService, Pending
  );
endinterface

// File: rtl/irq_sequencer.sv
// ---------------------------------------------------------------------------
// irq_sequencer
// Single-level interrupt sequencer. Rising edges on the source lines set
// sticky pending bits; the lowest-index pending source that is also enabled
// in the mask is requested from the branch unit. Once the pipeline acks, the
// return PC is saved and the handler runs until RETI resolves.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : irq_sequencer_if.slave
//            in : IrqLines, MaskWe, MaskIn, GlobalEn, IrqAck, PcIn, RetiDone
//            out: IRQ, VectorAddr, ReturnAddr, ActiveId, InService, Pending
// ---------------------------------------------------------------------------
module irq_sequencer #(
  parameter int                NUM_SRC     = 8,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] VECTOR_BASE = ADDR_W'(32'h0000_0100)
) (
  input logic            clk,
  input logic            rst,
  irq_sequencer_if.slave bus
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state, stateNext;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] prevLines;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ackClear;
  logic [ID_W-1:0]    activeId;
  logic [ID_W-1:0]    winner;
  logic               anyEligible;
  logic               latchWinner;
  logic               takeAck;

  assign rise     = bus.IrqLines & ~prevLines;
  assign eligible = pending & mask;

  // Fixed priority: scanning downwards lets the lowest set index win.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner      = '0;
    anyEligible = |eligible;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // FSM next-state and outputs. In REQ the request is already committed to
  // the pipeline, so mask/GlobalEn changes do not withdraw it.
  always_comb begin
    stateNext     = state;
    latchWinner   = 1'b0;
    takeAck       = 1'b0;
    bus.IRQ       = 1'b0;
    bus.InService = 1'b0;
    case (state)
      IDLE: begin
        if (bus.GlobalEn && anyEligible) begin
          latchWinner = 1'b1;
          stateNext   = REQ;
        end
      end
      REQ: begin
        bus.IRQ = 1'b1;
        if (bus.IrqAck) begin
          takeAck   = 1'b1;
          stateNext = SERVICE;
        end
      end
      SERVICE: begin
        bus.InService = 1'b1;
        if (bus.RetiDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // One-hot clear of the serviced source's pending bit on ack.
  always_comb begin
    ackClear = '0;
    if (takeAck) ackClear[activeId] = 1'b1;
  end

  // Datapath registers. A new edge on the acked source in the ack cycle is
  // OR-ed in after the clear, so the set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask           <= '0;
      prevLines      <= '0;
      pending        <= '0;
      activeId       <= '0;
      bus.ReturnAddr <= '0;
    end else begin
      prevLines <= bus.IrqLines;
      pending   <= (pending & ~ackClear) | rise;
      if (bus.MaskWe)  mask           <= bus.MaskIn;
      if (latchWinner) activeId       <= winner;
      if (takeAck)     bus.ReturnAddr <= bus.PcIn;
    end
  end

  assign bus.ActiveId   = activeId;
  assign bus.Pending    = pending;
  assign bus.VectorAddr = VECTOR_BASE + (ADDR_W'(activeId) << 2);
endmodule

// File: tb/tb_irq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_sequencer
// Directed self-checking bench for irq_sequencer. Inputs change 1 ns after
// the rising edge and outputs are sampled at the same point, so every check
// sees the state produced by the edge just passed.
// ---------------------------------------------------------------------------
module tb_irq_sequencer;
  localparam int NUM_SRC = 8;
  localparam int ADDR_W  = 32;

  logic clk;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;

  irq_sequencer_if #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W)) bus ();

  irq_sequencer #(
    .NUM_SRC    (NUM_SRC),
    .ADDR_W     (ADDR_W),
    .VECTOR_BASE(32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed 'h%0h required 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeMask(input logic [7:0] m);
    bus.MaskWe = 1'b1;
    bus.MaskIn = m;
    tick();
    bus.MaskWe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.IrqLines = '0;
    bus.MaskWe   = 1'b0;
    bus.MaskIn   = '0;
    bus.GlobalEn = 1'b0;
    bus.IrqAck   = 1'b0;
    bus.PcIn     = '0;
    bus.RetiDone = 1'b0;

    // ---- reset state ----
    #3;
    check("rst_irq",        64'(bus.IRQ),        64'd0);
    check("rst_inservice",  64'(bus.InService),  64'd0);
    check("rst_activeid",   64'(bus.ActiveId),   64'd0);
    check("rst_returnaddr", 64'(bus.ReturnAddr), 64'd0);
    check("rst_pending",    64'(bus.Pending),    64'd0);
    check("rst_vector",     64'(bus.VectorAddr), 64'h100);
    #4 rst = 1'b0;
    tick();

    // ---- basic request on line 3 ----
    bus.GlobalEn = 1'b1;
    writeMask(8'hFF);
    bus.IrqLines = 8'h08;
    tick();
    check("basic_pending",  64'(bus.Pending),    64'h08);
    check("basic_irq_early",64'(bus.IRQ),        64'd0);
    tick();
    check("basic_irq",      64'(bus.IRQ),        64'd1);
    check("basic_id",       64'(bus.ActiveId),   64'd3);
    check("basic_vector",   64'(bus.VectorAddr), 64'h10C);
    bus.IrqAck = 1'b1;
    bus.PcIn   = 32'h0000_0040;
    tick();
    bus.IrqAck = 1'b0;
    check("basic_ack_irq",  64'(bus.IRQ),        64'd0);
    check("basic_ack_isr",  64'(bus.InService),  64'd1);
    check("basic_ret",      64'(bus.ReturnAddr), 64'h40);
    check("basic_ack_pend", 64'(bus.Pending),    64'h00);
    bus.IrqLines = 8'h00;
    tick();
    bus.RetiDone = 1'b1;
    tick();
    bus.RetiDone = 1'b0;
    check("basic_reti_isr", 64'(bus.InService),  64'd0);
    check("basic_reti_irq", 64'(bus.IRQ),        64'd0);

    // ---- priority: lines 5 and 1 together ----
    bus.IrqLines = 8'h22;
    tick();
    check("prio_pending",   64'(bus.Pending),    64'h22);
    tick();
    bus.IrqLines = 8'h00;
    check("prio_irq1",      64'(bus.IRQ),        64'd1);
    check("prio_id1",       64'(bus.ActiveId),   64'd1);
    check("prio_vec1",      64'(bus.VectorAddr), 64'h104);
    bus.IrqAck = 1'b1;
    bus.PcIn   = 32'h0000_0080;
    tick();
    bus.IrqAck = 1'b0;
    check("prio_pend_after",64'(bus.Pending),    64'h20);
    bus.RetiDone = 1'b1;
    tick();
    bus.RetiDone = 1'b0;
    check("prio_idle_gap",  64'(bus.IRQ),        64'd0);
    tick();
    check("prio_irq5",      64'(bus.IRQ),        64'd1);
    check("prio_id5",       64'(bus.ActiveId),   64'd5);
    check("prio_vec5",      64'(bus.VectorAddr), 64'h114);
    bus.IrqAck = 1'b1;
    tick();
    bus.IrqAck   = 1'b0;
    bus.RetiDone = 1'b1;
    tick();
    bus.RetiDone = 1'b0;

    // ---- masking and global enable on line 2 ----
    writeMask(8'h00);
    bus.IrqLines = 8'h04;
    tick();
    check("mask_pending",   64'(bus.Pending),    64'h04);
    tick();
    tick();
    check("mask_irq_off",   64'(bus.IRQ),        64'd0);
    bus.GlobalEn = 1'b0;
    writeMask(8'h04);
    tick();
    tick();
    check("gen_irq_off",    64'(bus.IRQ),        64'd0);
    bus.GlobalEn = 1'b1;
    tick();
    check("gen_irq_on",     64'(bus.IRQ),        64'd1);
    check("gen_id",         64'(bus.ActiveId),   64'd2);
    bus.IrqAck = 1'b1;
    tick();
    bus.IrqAck   = 1'b0;
    bus.RetiDone = 1'b1;
    tick();
    bus.RetiDone = 1'b0;
    bus.IrqLines = 8'h00;

    // ---- commit in REQ for line 4 ----
    writeMask(8'hFF);
    bus.IrqLines = 8'h10;
    tick();
    tick();
    check("commit_irq",     64'(bus.IRQ),        64'd1);
    check("commit_id",      64'(bus.ActiveId),   64'd4);
    bus.MaskWe   = 1'b1;
    bus.MaskIn   = 8'h00;
    bus.GlobalEn = 1'b0;
    bus.IrqLines = 8'h11;
    tick();
    bus.MaskWe = 1'b0;
    check("commit_pending", 64'(bus.Pending),    64'h11);
    tick();
    check("commit_irq_hold",64'(bus.IRQ),        64'd1);
    check("commit_id_hold", 64'(bus.ActiveId),   64'd4);
    bus.IrqAck = 1'b1;
    bus.PcIn   = 32'h0000_0200;
    tick();
    bus.IrqAck = 1'b0;
    check("commit_isr",     64'(bus.InService),  64'd1);
    check("commit_ret",     64'(bus.ReturnAddr), 64'h200);
    check("commit_pend_ack",64'(bus.Pending),    64'h01);
    bus.GlobalEn = 1'b1;
    writeMask(8'hFF);
    bus.IrqLines = 8'h00;
    bus.RetiDone = 1'b1;
    tick();
    bus.RetiDone = 1'b0;
    tick();
    check("commit_irq0",    64'(bus.IRQ),        64'd1);
    check("commit_id0",     64'(bus.ActiveId),   64'd0);
    check("commit_vec0",    64'(bus.VectorAddr), 64'h100);

    // ---- collisions ----
    bus.RetiDone = 1'b1;
    tick();
    bus.RetiDone = 1'b0;
    check("reti_in_req_irq",64'(bus.IRQ),        64'd1);
    check("reti_in_req_isr",64'(bus.InService),  64'd0);
    bus.IrqLines = 8'h01;
    bus.IrqAck   = 1'b1;
    bus.PcIn     = 32'h0000_0300;
    tick();
    check("coll_isr",       64'(bus.InService),  64'd1);
    check("coll_pending",   64'(bus.Pending),    64'h01);
    check("coll_ret",       64'(bus.ReturnAddr), 64'h300);
    // Both strobes in SERVICE: only RetiDone acts.
    bus.RetiDone = 1'b1;
    bus.PcIn     = 32'h0000_0999;
    tick();
    bus.RetiDone = 1'b0;
    check("both_isr",       64'(bus.InService),  64'd0);
    check("both_ret",       64'(bus.ReturnAddr), 64'h300);
    check("both_pending",   64'(bus.Pending),    64'h01);
    // IrqAck held through the IDLE cycle is ignored there.
    tick();
    bus.IrqAck = 1'b0;
    check("ack_idle_irq",   64'(bus.IRQ),        64'd1);
    check("ack_idle_isr",   64'(bus.InService),  64'd0);
    check("ack_idle_pend",  64'(bus.Pending),    64'h01);
    bus.IrqAck = 1'b1;
    tick();
    bus.IrqAck = 1'b0;
    check("svc_isr",        64'(bus.InService),  64'd1);
    check("svc_pending",    64'(bus.Pending),    64'h00);

    // ---- async reset while in SERVICE ----
    bus.IrqLines = 8'h02;
    tick();
    check("pre_rst_pending",64'(bus.Pending),    64'h02);
    #2 rst = 1'b1;
    #1;
    check("arst_isr",       64'(bus.InService),  64'd0);
    check("arst_irq",       64'(bus.IRQ),        64'd0);
    check("arst_pending",   64'(bus.Pending),    64'h00);
    check("arst_ret",       64'(bus.ReturnAddr), 64'h0);
    check("arst_id",        64'(bus.ActiveId),   64'd0);
    #2 rst = 1'b0;
    bus.IrqLines = 8'h00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Collects NUM_SRC external interrupt lines and selects one by fixed priority.
- Drives the single IRQ input of the branch unit and supplies the handler vector address.
- Captures the return PC when the pipeline accepts the interrupt.
- Tracks the in-service state until the RETI instruction completes. One level only, no nesting.

Parameters:
- NUM_SRC, 8, number of interrupt source lines (2..16).
- ADDR_W, 32, PC/vector address width.
- VECTOR_BASE, 32'h0000_0100, address of vector slot 0; each slot is 4 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IrqLines  in  NUM_SRC  raw level interrupt requests, already synchronous to clk.
- MaskWe  in  1  write strobe for the enable mask.
- MaskIn  in  NUM_SRC  new enable mask; bit i=1 enables source i.
- GlobalEn  in  1  global interrupt enable.
- IrqAck  in  1  pipeline has flushed fetch/decode and redirected PC to VectorAddr (one-cycle pulse).
- PcIn  in  ADDR_W  PC to resume at, valid when IrqAck=1.
- RetiDone  in  1  RETI instruction resolved in the branch unit (one-cycle pulse).
- IRQ  out  1  interrupt request to the branch unit.
- VectorAddr  out  ADDR_W  handler address for ActiveId.
- ReturnAddr  out  ADDR_W  saved return PC, used by the RETI next-PC path.
- ActiveId  out  $clog2(NUM_SRC)  index of the requesting or in-service source.
- InService  out  1  handler currently executing.
- Pending  out  NUM_SRC  pending register, for debug/status.

Behaviour:
- Reset (async, immediate):
  - State=IDLE; IRQ=0, InService=0, ActiveId=0, ReturnAddr=0, Pending=0.
  - Mask=0 (all sources disabled); previous-line register=0.
- Edge detection:
  - prev <= IrqLines each cycle.
  - A rising edge (IrqLines[i] & ~prev[i]) sets Pending[i] on the next edge, regardless of the mask.
  - Pending is sticky until serviced.
- Mask: MaskWe=1 loads MaskIn at the clock edge; takes effect for selection from the following cycle.
- Selection: Eligible = Pending & Mask. Winner = lowest set index of Eligible (index 0 = highest priority). Selection is combinational.
- FSM has 3 states:
  - IDLE: IRQ=0, InService=0. If GlobalEn & |Eligible, latch ActiveId=winner and go to REQ. Asserting IRQ is therefore 1 cycle after the pending bit is visible.
  - REQ: IRQ=1. ActiveId is frozen; a higher-priority arrival does not preempt the choice. Clearing the mask bit or GlobalEn does not withdraw the request, because it is already committed to the pipeline. On IrqAck: ReturnAddr<=PcIn, Pending[ActiveId]<=0, go to SERVICE; IRQ drops the cycle after the ack.
  - SERVICE: IRQ=0, InService=1. New edges still set Pending. On RetiDone go to IDLE; re-arbitration happens there, so back-to-back interrupts have a 1-cycle IDLE gap.
- VectorAddr = VECTOR_BASE + (ActiveId << 2), computed modulo 2^ADDR_W and valid in every state.
- Simultaneous events:
  - Rising edge on source ActiveId in the same cycle as IrqAck: the set wins, so Pending stays 1.
  - IrqAck in IDLE or SERVICE: ignored. RetiDone in IDLE or REQ: ignored.
  - IrqAck and RetiDone in the same cycle: only the one valid for the current state acts.
- Reset mid-operation: all state is cleared immediately and any in-flight request or service is dropped.

Test Plan:
- Reset then basic request:
  - Stimulus: rst pulse; Mask=8'hFF, GlobalEn=1; rising edge on line 3; IrqAck with PcIn=32'h0000_0040 two cycles later.
  - Response: Pending=8'h08; IRQ rises 2 cycles after the edge; VectorAddr=32'h0000_010C; after ack ReturnAddr=32'h40, Pending=0, InService=1; RetiDone returns to IDLE with IRQ=0.
- Priority:
  - Stimulus: lines 5 and 1 rise in the same cycle.
  - Response: ActiveId=1, VectorAddr=32'h104. After RETI and 1 IDLE cycle, ActiveId=5, VectorAddr=32'h114.
- Masking and global enable:
  - Stimulus: Mask=8'h00 with an edge on line 2.
  - Response: Pending=8'h04, IRQ stays 0. After MaskIn=8'h04 is written, IRQ rises; GlobalEn=0 blocks IRQ in IDLE.
- Commit in REQ:
  - Stimulus: while in REQ for line 4, clear Mask and GlobalEn, then raise line 0.
  - Response: IRQ stays 1, ActiveId stays 4, and ack is honoured. Line 0 is serviced after RETI, once the enables are restored.
- Collisions:
  - Stimulus: edge on the active line in the ack cycle; then RetiDone while in REQ.
  - Response: Pending bit remains 1; RetiDone in REQ has no effect.
- Async reset in SERVICE:
  - Stimulus: assert rst mid-clock while in SERVICE.
  - Response: InService, IRQ and Pending go to 0 without waiting for a clock edge.
